// File: rtl/ecc_defines_pkg.sv
// rtl/ecc_defines_pkg.sv - shared ECC controller types and arbiter defaults
package ecc_defines_pkg;

  localparam int ECC_ARB_NUM_CH_DEF = 4;
  localparam int ECC_ARB_DEPTH_DEF  = 4;

  typedef enum logic [0:0] {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } ecc_arb_state_e;

  // 32-bit default view of one request channel
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } ecc_req_t;

endpackage

// File: rtl/ecc_req_arb_idfifo.sv
// rtl/ecc_req_arb_idfifo.sv - in-order FIFO of channel IDs for outstanding reads
module ecc_req_arb_idfifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [ID_W-1:0]  head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full  = (int'(count) == DEPTH);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ecc_req_arb.sv
// rtl/ecc_req_arb.sv - round-robin ECC request arbiter with in-order read response routing
// Optional grant locking is enabled by defining ECC_REQ_ARB_LOCK_EN.
module ecc_req_arb
  import ecc_defines_pkg::*;
#(
  parameter int NUM_CH = ECC_ARB_NUM_CH_DEF,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = ECC_ARB_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          up_valid,
  output logic [NUM_CH-1:0]          up_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   up_addr,
  input  logic [NUM_CH*DATA_W-1:0]   up_wdata,
  input  logic [NUM_CH-1:0]          up_write,
  input  logic [NUM_CH-1:0]          up_lock,
  output logic [NUM_CH-1:0]          up_rsp_valid,
  output logic [DATA_W-1:0]          up_rsp_rdata,
  output logic                       dn_valid,
  input  logic                       dn_ready,
  output logic [ADDR_W-1:0]          dn_addr,
  output logic [DATA_W-1:0]          dn_wdata,
  output logic                       dn_write,
  input  logic                       dn_rsp_valid,
  input  logic [DATA_W-1:0]          dn_rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] rd_pending,
  output logic                       rsp_err
);

  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] eligible;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic              hs;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   fifo_head;
  logic              hold_ptr;
  logic              lock_block;

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_CH - 1) ? '0 : id + 1'b1;
  endfunction

`ifdef ECC_REQ_ARB_LOCK_EN
  localparam logic [0:0] S_OPEN   = ARB_OPEN;
  localparam logic [0:0] S_LOCKED = ARB_LOCKED;

  logic [0:0]      state;
  logic [ID_W-1:0] owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_OPEN;
      owner <= '0;
    end else if (hs) begin
      case (state)
        S_OPEN: begin
          if (up_lock[win_id]) begin
            state <= S_LOCKED;
            owner <= win_id;
          end
        end
        default: begin
          if (!up_lock[win_id]) state <= S_OPEN;
        end
      endcase
    end
  end

  // rr_ptr stays frozen for every owner transfer that keeps the lock
  assign hold_ptr   = (state == S_LOCKED) && up_lock[win_id];
  assign lock_block = (state == S_LOCKED);
`else
  logic unused_lock;
  logic [ID_W-1:0] owner;

  assign unused_lock = ^up_lock;
  assign owner       = '0;
  assign hold_ptr    = 1'b0;
  assign lock_block  = 1'b0;
`endif

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = up_valid[i] && (up_write[i] || !fifo_full);
      if (lock_block && (ID_W'(i) != owner)) eligible[i] = 1'b0;
    end
    if (reset) eligible = '0;
  end

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    dn_valid = win_found;
    dn_addr  = '0;
    dn_wdata = '0;
    dn_write = 1'b0;
    up_ready = '0;
    if (win_found) begin
      dn_addr          = up_addr[int'(win_id)*ADDR_W +: ADDR_W];
      dn_wdata         = up_wdata[int'(win_id)*DATA_W +: DATA_W];
      dn_write         = up_write[win_id];
      up_ready[win_id] = dn_ready;
    end
  end

  assign hs   = win_found && dn_ready;
  assign push = hs && !dn_write;
  assign pop  = dn_rsp_valid && !fifo_empty && !reset;

  always_comb begin
    up_rsp_valid = '0;
    up_rsp_rdata = '0;
    if (pop) begin
      up_rsp_valid[fifo_head] = 1'b1;
      up_rsp_rdata            = dn_rsp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (dn_rsp_valid && fifo_empty) rsp_err <= 1'b1;
      if (hs && !hold_ptr) rr_ptr <= id_inc(win_id);
    end
  end

  ecc_req_arb_idfifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_idfifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (win_id),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rd_pending),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_ecc_req_arb.sv
// tb/tb_ecc_req_arb.sv - table-driven bench for ecc_req_arb (lock vectors under ECC_REQ_ARB_LOCK_EN)
module tb_ecc_req_arb;

  logic         clk;
  logic         reset;
  logic [3:0]   up_valid;
  logic [3:0]   up_ready;
  logic [127:0] up_addr;
  logic [127:0] up_wdata;
  logic [3:0]   up_write;
  logic [3:0]   up_lock;
  logic [3:0]   up_rsp_valid;
  logic [31:0]  up_rsp_rdata;
  logic         dn_valid;
  logic         dn_ready;
  logic [31:0]  dn_addr;
  logic [31:0]  dn_wdata;
  logic         dn_write;
  logic         dn_rsp_valid;
  logic [31:0]  dn_rsp_rdata;
  logic [2:0]   rd_pending;
  logic         rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  ecc_req_arb #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .up_valid     (up_valid),
    .up_ready     (up_ready),
    .up_addr      (up_addr),
    .up_wdata     (up_wdata),
    .up_write     (up_write),
    .up_lock      (up_lock),
    .up_rsp_valid (up_rsp_valid),
    .up_rsp_rdata (up_rsp_rdata),
    .dn_valid     (dn_valid),
    .dn_ready     (dn_ready),
    .dn_addr      (dn_addr),
    .dn_wdata     (dn_wdata),
    .dn_write     (dn_write),
    .dn_rsp_valid (dn_rsp_valid),
    .dn_rsp_rdata (dn_rsp_rdata),
    .rd_pending   (rd_pending),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [3:0]  lock;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    int          win;
    logic [3:0]  exp_rsp;
    int          pend;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  vec_t lvecs[$];

  function automatic vec_t mk(logic [3:0] valid, logic [3:0] write, logic [3:0] lock,
                              logic rdy, logic rspv, logic [31:0] rspd,
                              int win, logic [3:0] exp_rsp, int pend, logic err);
    vec_t v;
    v.valid = valid; v.write = write; v.lock = lock; v.rdy = rdy;
    v.rspv = rspv; v.rspd = rspd; v.win = win; v.exp_rsp = exp_rsp;
    v.pend = pend; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_ready;
    @(negedge clk);
    up_valid     = v.valid;
    up_write     = v.write;
    up_lock      = v.lock;
    dn_ready     = v.rdy;
    dn_rsp_valid = v.rspv;
    dn_rsp_rdata = v.rspd;
    #1;
    e_addr  = (v.win >= 0) ? 32'h10 * v.win : 32'h0;
    e_wdata = (v.win >= 0) ? 32'hA5A5A5A4 + v.win : 32'h0;
    e_ready = (v.win >= 0 && v.rdy) ? (4'b0001 << v.win) : 4'b0000;
    chk({tag, " dn_valid"}, {31'b0, dn_valid}, {31'b0, v.win >= 0});
    chk({tag, " dn_addr"}, dn_addr, e_addr);
    chk({tag, " dn_wdata"}, dn_wdata, e_wdata);
    if (v.win >= 0) chk({tag, " dn_write"}, {31'b0, dn_write}, {31'b0, v.write[v.win]});
    chk({tag, " up_ready"}, {28'b0, up_ready}, {28'b0, e_ready});
    chk({tag, " up_rsp_valid"}, {28'b0, up_rsp_valid}, {28'b0, v.exp_rsp});
    chk({tag, " up_rsp_rdata"}, up_rsp_rdata, (v.exp_rsp != 4'b0) ? v.rspd : 32'h0);
    chk({tag, " rd_pending"}, {29'b0, rd_pending}, 32'(v.pend));
    chk({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, v.err});
  endtask

  // Reset with every input busy: all outputs must still read zero.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; up_valid = 4'hF; up_write = 4'h5; up_lock = 4'hF;
    dn_ready = 1'b1; dn_rsp_valid = 1'b1; dn_rsp_rdata = 32'hDEAD;
    @(negedge clk);
    #1;
    chk({tag, " rst dn_valid"}, {31'b0, dn_valid}, 32'h0);
    chk({tag, " rst dn_addr"}, dn_addr, 32'h0);
    chk({tag, " rst up_ready"}, {28'b0, up_ready}, 32'h0);
    chk({tag, " rst up_rsp_valid"}, {28'b0, up_rsp_valid}, 32'h0);
    chk({tag, " rst up_rsp_rdata"}, up_rsp_rdata, 32'h0);
    chk({tag, " rst rd_pending"}, {29'b0, rd_pending}, 32'h0);
    chk({tag, " rst rsp_err"}, {31'b0, rsp_err}, 32'h0);
    reset = 1'b0; up_valid = 4'h0; up_write = 4'h0; up_lock = 4'h0;
    dn_ready = 1'b0; dn_rsp_valid = 1'b0; dn_rsp_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    up_valid = '0; up_write = '0; up_lock = '0;
    dn_ready = 1'b0; dn_rsp_valid = 1'b0; dn_rsp_rdata = '0;
    up_addr  = {32'h30, 32'h20, 32'h10, 32'h00};
    up_wdata = {32'hA5A5A5A7, 32'hA5A5A5A6, 32'hA5A5A5A5, 32'hA5A5A5A4};

    //                valid  write  lock  rdy rspv rspd           win exp_rsp pend err
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 32'h0,          -1, 4'h0, 0, 0));
    vecs.push_back(mk(4'h2, 4'h2, 4'h0, 1, 0, 32'h0,           1, 4'h0, 0, 0));
    vecs.push_back(mk(4'h5, 4'h5, 4'h0, 1, 0, 32'h0,           2, 4'h0, 0, 0));
    vecs.push_back(mk(4'h8, 4'h8, 4'h0, 1, 0, 32'h0,           3, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'h0, 1, 0, 32'h0,           0, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'h0, 1, 0, 32'h0,           1, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'h0, 1, 0, 32'h0,           2, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'h0, 1, 0, 32'h0,           3, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'h0, 1, 0, 32'h0,           0, 4'h0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'h0, 0, 0, 32'h0,           1, 4'h0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 32'h0,           2, 4'h0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 32'h0,           2, 4'h0, 1, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 32'h0,           2, 4'h0, 2, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 32'h0,           2, 4'h0, 3, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 32'h0,          -1, 4'h0, 4, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 1, 32'h1234,       -1, 4'h4, 4, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 0, 32'h0,           2, 4'h0, 3, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'h11,         -1, 4'h4, 4, 0));
    vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 1, 32'h22,          0, 4'h4, 3, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'h33,         -1, 4'h4, 3, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'h44,         -1, 4'h4, 2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'h55,         -1, 4'h1, 1, 0));
    vecs.push_back(mk(4'h9, 4'h0, 4'h0, 1, 0, 32'h0,           3, 4'h0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 0, 32'h0,           0, 4'h0, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'hAA,         -1, 4'h8, 2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'hBB,         -1, 4'h1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 32'h66,         -1, 4'h0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 32'h0,          -1, 4'h0, 0, 1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0, 32'h0,          -1, 4'h0, 0, 1));

    do_reset("init");
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Sticky error must clear on reset; reads issued before it are forgotten.
    do_reset("err");
    run_vec(mk(4'h0, 4'h0, 4'h0, 1, 0, 32'h0, -1, 4'h0, 0, 0), "post_rst");

`ifdef ECC_REQ_ARB_LOCK_EN
    lvecs.push_back(mk(4'h1, 4'h1, 4'h0, 1, 0, 32'h0,  0, 4'h0, 0, 0));
    lvecs.push_back(mk(4'h7, 4'h7, 4'h2, 1, 0, 32'h0,  1, 4'h0, 0, 0));
    lvecs.push_back(mk(4'h7, 4'h7, 4'h2, 1, 0, 32'h0,  1, 4'h0, 0, 0));
    lvecs.push_back(mk(4'h5, 4'h5, 4'h0, 1, 0, 32'h0, -1, 4'h0, 0, 0));
    lvecs.push_back(mk(4'h7, 4'h7, 4'h0, 1, 0, 32'h0,  1, 4'h0, 0, 0));
    lvecs.push_back(mk(4'h7, 4'h7, 4'h0, 1, 0, 32'h0,  2, 4'h0, 0, 0));
    lvecs.push_back(mk(4'h3, 4'h3, 4'h0, 1, 0, 32'h0,  0, 4'h0, 0, 0));
    do_reset("lock");
    for (int i = 0; i < lvecs.size(); i++) run_vec(lvecs[i], $sformatf("l%0d", i));
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
